// File: rtl/alu_req_arbiter_if.sv
// Request/response and ALU-side bundle for alu_req_arbiter.
// The arbiter connects through the slave modport; clients and the ALU sit on the master side.
interface alu_req_arbiter_if #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 4
);
  logic [1:0]          req_valid;
  logic [2*DATA_W-1:0] req_a;
  logic [2*DATA_W-1:0] req_b;
  logic [2*OP_W-1:0]   req_op;
  logic [1:0]          req_ready;
  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_id;
  logic [DATA_W-1:0]   rsp_result;
  logic                rsp_carry;
  logic                rsp_ovf;
  logic                rsp_err;
  logic                busy;
  logic [DATA_W-1:0]   alu_a;
  logic [DATA_W-1:0]   alu_b;
  logic [OP_W-1:0]     alu_op;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_carry;
  logic                alu_ovf;

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready, alu_result, alu_carry, alu_ovf,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_ovf, rsp_err, busy,
           alu_a, alu_b, alu_op
  );

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready, alu_result, alu_carry, alu_ovf,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_ovf, rsp_err, busy,
           alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin two-requester front end for one shared combinational ALU, one op in flight.
// Optional macro ALU_OPCODE_CHECK_EN: opcodes above MAX_OPCODE are answered with rsp_err, never issued.
module alu_req_arbiter #(
  parameter int DATA_W     = 4,
  parameter int OP_W       = 4,
  parameter int MAX_OPCODE = 10
) (
  input  logic               clk,
  input  logic               rst,
  alu_req_arbiter_if.slave   bus
);

`ifdef ALU_OPCODE_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif
  localparam logic [OP_W-1:0] MAX_OP = OP_W'(MAX_OPCODE);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_rr_ptr;
  logic                r_rsp_id_p0;
  logic [DATA_W-1:0]   r_alu_a_p0;
  logic [DATA_W-1:0]   r_alu_b_p0;
  logic [OP_W-1:0]     r_alu_op_p0;
  logic [DATA_W-1:0]   r_rsp_result_p1;
  logic                r_rsp_carry_p1;
  logic                r_rsp_ovf_p1;
  logic                r_rsp_err_p1;

  logic                w_grant_vld;
  logic                w_grant;
  logic [1:0]          w_req_ready;
  logic                w_hs;
  logic [DATA_W-1:0]   w_sel_a;
  logic [DATA_W-1:0]   w_sel_b;
  logic [OP_W-1:0]     w_sel_op;
  logic                w_illegal;

  // The rr_ptr side has priority; the other side only wins when rr_ptr is idle.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = r_rr_ptr;
    if (bus.req_valid[r_rr_ptr]) begin
      w_grant_vld = 1'b1;
    end else if (bus.req_valid[~r_rr_ptr]) begin
      w_grant_vld = 1'b1;
      w_grant     = ~r_rr_ptr;
    end
    w_req_ready = 2'b00;
    if ((r_state == IDLE) && w_grant_vld) w_req_ready[w_grant] = 1'b1;
  end

  assign w_hs      = |(bus.req_valid & w_req_ready);
  assign w_sel_a   = w_grant ? bus.req_a[2*DATA_W-1:DATA_W] : bus.req_a[DATA_W-1:0];
  assign w_sel_b   = w_grant ? bus.req_b[2*DATA_W-1:DATA_W] : bus.req_b[DATA_W-1:0];
  assign w_sel_op  = w_grant ? bus.req_op[2*OP_W-1:OP_W]    : bus.req_op[OP_W-1:0];
  assign w_illegal = CHECK_EN && (w_sel_op > MAX_OP);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_hs) w_state_nxt = w_illegal ? RESP : EXEC;
      EXEC:    w_state_nxt = RESP;
      RESP:    if (bus.rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // p0: accept and register ALU inputs; p1: capture ALU outputs for the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_rr_ptr        <= 1'b0;
      r_rsp_id_p0     <= 1'b0;
      r_alu_a_p0      <= '0;
      r_alu_b_p0      <= '0;
      r_alu_op_p0     <= '0;
      r_rsp_result_p1 <= '0;
      r_rsp_carry_p1  <= 1'b0;
      r_rsp_ovf_p1    <= 1'b0;
      r_rsp_err_p1    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_rsp_id_p0 <= w_grant;
            if (w_illegal) begin
              r_rsp_result_p1 <= '0;
              r_rsp_carry_p1  <= 1'b0;
              r_rsp_ovf_p1    <= 1'b0;
              r_rsp_err_p1    <= 1'b1;
            end else begin
              r_alu_a_p0   <= w_sel_a;
              r_alu_b_p0   <= w_sel_b;
              r_alu_op_p0  <= w_sel_op;
              r_rsp_err_p1 <= 1'b0;
            end
          end
        end
        EXEC: begin
          r_rsp_result_p1 <= bus.alu_result;
          r_rsp_carry_p1  <= bus.alu_carry;
          r_rsp_ovf_p1    <= bus.alu_ovf;
        end
        RESP: begin
          if (bus.rsp_ready) r_rr_ptr <= ~r_rsp_id_p0;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.rsp_valid  = (r_state == RESP);
  assign bus.rsp_id     = r_rsp_id_p0;
  assign bus.rsp_result = r_rsp_result_p1;
  assign bus.rsp_carry  = r_rsp_carry_p1;
  assign bus.rsp_ovf    = r_rsp_ovf_p1;
  assign bus.rsp_err    = r_rsp_err_p1;
  assign bus.busy       = (r_state != IDLE);
  assign bus.alu_a      = r_alu_a_p0;
  assign bus.alu_b      = r_alu_b_p0;
  assign bus.alu_op     = r_alu_op_p0;

endmodule
